// File: rtl/ps2_key_pkg.sv
// Shared constants and FSM encoding for the PS/2 key-event sequencer.
package ps2_key_pkg;

    localparam logic [7:0] PS2_E0         = 8'hE0;
    localparam logic [7:0] PS2_F0         = 8'hF0;
    localparam logic [7:0] PS2_E1         = 8'hE1;
    localparam logic [7:0] PS2_BAT        = 8'hAA;
    localparam logic [7:0] PS2_ACK        = 8'hFA;
    localparam logic [7:0] PS2_ECHO       = 8'hEE;
    localparam logic [7:0] PS2_RESEND     = 8'hFE;
    localparam logic [7:0] PS2_PAUSE_CODE = 8'h77;

    localparam int EVT_W      = 10;
    localparam int PAUSE_SKIP = 7;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_POP    = 2'd1,
        ST_SETTLE = 2'd2,
        ST_DECODE = 2'd3
    } pop_state_e;

endpackage

// File: rtl/ps2_key_if.sv
// Receiver-side and CPU-side signals of the key-event sequencer, plus FSM debug state.
interface ps2_key_if #(
    parameter int EVT_DEPTH = 8
);
    import ps2_key_pkg::*;

    localparam int CNT_W = $clog2(EVT_DEPTH) + 1;

    // Receiver handshake: kb_data is valid while kb_ready=1; a single low cycle of
    // kb_rdn consumes the head byte. CPU side: one cpu_rd strobe pops one event.
    logic [7:0]       kb_data;
    logic             kb_ready;
    logic             kb_overflow;
    logic             kb_rdn;
    logic             cpu_rd;
    logic [15:0]      evt_data;
    logic [CNT_W-1:0] evt_count;
    logic             irq;
    pop_state_e       dbg_state;

    modport master (
        input  kb_data, kb_ready, kb_overflow, cpu_rd,
        output kb_rdn, evt_data, evt_count, irq, dbg_state
    );

    modport slave (
        output kb_data, kb_ready, kb_overflow, cpu_rd,
        input  kb_rdn, evt_data, evt_count, irq, dbg_state
    );

endinterface

// File: rtl/ps2_evt_fifo.sv
// Synchronous event FIFO with combinational head; push into full succeeds only with a pop.
module ps2_evt_fifo #(
    parameter int W     = 10,
    parameter int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic           push_i,
    input  logic           pop_i,
    input  logic [W-1:0]   din_i,
    output logic [W-1:0]   head_o,
    output logic           full_o,
    output logic           empty_o,
    output logic [PTR_W:0] count_o
);
    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic             do_push, do_pop;

    assign full_o  = (count_q == (PTR_W + 1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || pop_i);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_q + (PTR_W + 1)'(do_push) - (PTR_W + 1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din_i;
    end

endmodule

// File: rtl/ps2_key_ctrl.sv
// PS/2 scancode-to-key-event sequencer with CPU event FIFO.
// Optional typematic repeat filter: define PS2_KEY_REPEAT_FILTER_EN.
module ps2_key_ctrl
    import ps2_key_pkg::*;
#(
    parameter int EVT_DEPTH   = 8,
    parameter int TIMEOUT_CYC = 2_000_000
) (
    input logic       clk,
    input logic       rstn,
    ps2_key_if.master bus
);
    localparam int CNT_W = $clog2(EVT_DEPTH) + 1;
    localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);

    pop_state_e       state_q, state_d;
    logic [7:0]       byte_q, byte_d;
    logic             ext_q, ext_d, brk_q, brk_d, lost_q, lost_d;
    logic [2:0]       pause_q, pause_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic             ovf_q, rd_s1_q, rd_s2_q, rd_s3_q, pop_q;
    logic             push, lost_set, pending, is_ctrl;
    logic             fifo_full, fifo_empty;
    logic [EVT_W-1:0] push_evt, fifo_head;
    logic [CNT_W-1:0] fifo_count;
`ifdef PS2_KEY_REPEAT_FILTER_EN
    logic [9:0]       last_make_q, last_make_d;
`endif

    assign pending = ext_q || brk_q || (pause_q != 3'd0);
    assign is_ctrl = (byte_q == PS2_BAT) || (byte_q == PS2_ACK) ||
                     (byte_q == PS2_ECHO) || (byte_q == PS2_RESEND);

    always_comb begin
        state_d  = state_q;
        byte_d   = byte_q;
        ext_d    = ext_q;
        brk_d    = brk_q;
        pause_d  = pause_q;
        timer_d  = timer_q;
        lost_d   = lost_q;
        push     = 1'b0;
        push_evt = '0;
        lost_set = 1'b0;
`ifdef PS2_KEY_REPEAT_FILTER_EN
        last_make_d = last_make_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.kb_ready) begin
                    byte_d  = bus.kb_data;
                    state_d = ST_POP;
                end
            end
            ST_POP:    state_d = ST_SETTLE;
            ST_SETTLE: state_d = ST_DECODE;
            ST_DECODE: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase

        // A stale prefix is dropped silently once its wait budget runs out.
        if (pending && timer_q != '0) begin
            timer_d = timer_q - TMR_W'(1);
            if (timer_q == TMR_W'(1)) begin
                ext_d   = 1'b0;
                brk_d   = 1'b0;
                pause_d = 3'd0;
            end
        end

        if (state_q == ST_DECODE) begin
            timer_d = TMR_W'(TIMEOUT_CYC);
            if (pause_q != 3'd0) begin
                pause_d = pause_q - 3'd1;
                if (pause_q == 3'd1) begin
                    push     = 1'b1;
                    push_evt = {1'b1, 1'b0, PS2_PAUSE_CODE};
                end
            end else if (byte_q == PS2_E1) begin
                pause_d = 3'(PAUSE_SKIP);
            end else if (byte_q == PS2_E0) begin
                ext_d = 1'b1;
            end else if (byte_q == PS2_F0) begin
                brk_d = 1'b1;
            end else if (byte_q == 8'h00 || byte_q == 8'hFF) begin
                lost_set = 1'b1;
                ext_d    = 1'b0;
                brk_d    = 1'b0;
            end else if (!(is_ctrl && !ext_q && !brk_q)) begin
                push     = 1'b1;
                push_evt = {ext_q, brk_q, byte_q};
                ext_d    = 1'b0;
                brk_d    = 1'b0;
`ifdef PS2_KEY_REPEAT_FILTER_EN
                if (!brk_q) begin
                    if (last_make_q == {1'b1, ext_q, byte_q}) push = 1'b0;
                    else last_make_d = {1'b1, ext_q, byte_q};
                end else if (last_make_q == {1'b1, ext_q, byte_q}) begin
                    last_make_d = '0;
                end
`endif
            end
        end

        // New loss evidence outranks the clear caused by a simultaneous CPU pop.
        if (pop_q) lost_d = 1'b0;
        if (lost_set || (push && fifo_full && !pop_q) || (bus.kb_overflow && !ovf_q))
            lost_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            byte_q  <= '0;
            ext_q   <= 1'b0;
            brk_q   <= 1'b0;
            pause_q <= 3'd0;
            timer_q <= '0;
            lost_q  <= 1'b0;
            ovf_q   <= 1'b0;
            rd_s1_q <= 1'b0;
            rd_s2_q <= 1'b0;
            rd_s3_q <= 1'b0;
            pop_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            byte_q  <= byte_d;
            ext_q   <= ext_d;
            brk_q   <= brk_d;
            pause_q <= pause_d;
            timer_q <= timer_d;
            lost_q  <= lost_d;
            ovf_q   <= bus.kb_overflow;
            rd_s1_q <= bus.cpu_rd;
            rd_s2_q <= rd_s1_q;
            rd_s3_q <= rd_s2_q;
            pop_q   <= rd_s2_q && !rd_s3_q;
        end
    end

`ifdef PS2_KEY_REPEAT_FILTER_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) last_make_q <= '0;
        else       last_make_q <= last_make_d;
    end
`endif

    ps2_evt_fifo #(
        .W     (EVT_W),
        .DEPTH (EVT_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .push_i  (push),
        .pop_i   (pop_q),
        .din_i   (push_evt),
        .head_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign bus.kb_rdn    = (state_q != ST_POP);
    assign bus.evt_data  = {~fifo_empty, lost_q, 4'b0000,
                            fifo_empty ? {EVT_W{1'b0}} : fifo_head};
    assign bus.evt_count = fifo_count;
    assign bus.irq       = ~fifo_empty;
    assign bus.dbg_state = state_q;

endmodule
